pipe_rate_gen: RTL and testbench
================================

# pipe_rate_gen

Parametrised multi-channel rate generator for game-timing strobes such as pipe scroll, spawn and animation ticks. Each channel has a free-running counter with a programmable period and threshold, and drives a registered output in one of two modes:
- square/level mode (duty set by threshold);
- single-cycle pulse mode.

A shared enable pauses all channels and a synchronous restart re-phases them. The block sits between the system clock domain and game-logic consumers, replacing fixed-width slow-clock counters.

## Interface
- WIDTH, 10, counter/period/threshold width per channel
- CHANNELS, 2, number of independent channels (≥1)
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  global count enable; 0 freezes all counters
- restart  in  1  synchronous clear of all counters and outputs; priority over en
- mode  in  CHANNELS  per channel: 0 = level (square), 1 = pulse
- period  in  CHANNELS*WIDTH  per-channel terminal count P, channel i at [i*WIDTH +: WIDTH]; cycle length P+1 enabled clocks
- thresh  in  CHANNELS*WIDTH  per-channel level threshold T, same packing
- out  out  CHANNELS  registered channel output
- wrap  out  CHANNELS  registered one-cycle pulse on counter wrap
- count  out  CHANNELS*WIDTH  current counter value per channel, same packing

## Operation
- Reset (reset_n=0, async): every cnt_i, out, and wrap = 0. Released synchronously in effect; the first count occurs on the first rising edge with reset_n=1.
- Priority per edge: reset_n > restart > en > hold.
- restart=1: cnt_i <= 0, out <= 0, wrap <= 0 for all channels, regardless of en.
- en=1, per channel i, with c = pre-edge cnt_i:
  - cnt_i <= (c >= P_i) ? 0 : c+1
  - wrap_i <= (c >= P_i)
  - level mode: out_i <= (c > T_i)
  - pulse mode: out_i <= (c >= P_i)
- en=0: cnt_i holds and wrap_i <= 0. In level mode out_i holds; in pulse mode out_i <= 0.
- Comparisons are unsigned, full WIDTH. Increment never overflows because the wrap test uses >=.
- P_i=0: wrap_i and pulse out_i are high every enabled cycle; cnt_i stays 0.
- Period lowered mid-count so that c > new P: the channel wraps on the next enabled edge. No lockup and no 2^WIDTH run-out.
- T_i >= P_i in level mode: out_i is constantly 0. T_i=0 with P_i≥1: out_i is high for P_i of every P_i+1 cycles.
- mode, period, and thresh are sampled every edge with no shadowing. Changes take effect on the next edge.
- Defaults P=2^WIDTH−1 and T=2^(WIDTH−1)−1 in level mode give a 50%-duty square wave of period 2^WIDTH.

## Timing
- count is a direct register view, with zero latency after the edge.
- out and wrap are registered from the pre-edge count, so they lag the corresponding count value by one cycle.
- Level-mode out_i rises on the edge where pre-edge c = T_i+1. It falls on the edge where pre-edge c = 0, i.e. the edge after the wrap.
- Pulse and wrap are exactly one clk wide per wrap while en stays 1.
- Channels are fully independent, with no cross-channel arbitration. Simultaneous wraps on all channels are allowed.
- restart and en are both synchronous. restart asserted together with en=1 yields cnt=0 (restart wins).
- Reset asserted mid-period clears state immediately (asynchronously). No residual pulse after release.

## Test plan
- Default config, CHANNELS=1, WIDTH=10, P=1023, T=511, level, en=1 after reset release:
  - out goes 1 after edge 513 and 0 after edge 1025, i.e. 512 high / 512 low repeating.
  - wrap is high for one cycle after edges 1024, 2048, ….
- Pulse mode, P=4:
  - out and wrap are high for one cycle every 5 clocks.
  - count sequence is 0,1,2,3,4,0.
  - P=0 makes out constantly 1 and count constantly 0.
- Enable gating, P=9, T=4, level:
  - Drop en at count=7 for 6 cycles; count holds at 7 and out holds 1.
  - Resume; wrap occurs 3 enabled edges later.
  - Repeat in pulse mode: out is 0 during the pause.
- Period shrink at count=50 from P=99 to P=20: next enabled edge gives count 0 and a wrap pulse. Subsequent period is 21 clocks.
- Two channels, P0=3 level T0=1, P1=6 pulse, run 42 clocks:
  - Ch0 out pattern is 0,0,1,1 repeating, shifted by one.
  - Ch1 pulses every 7 clocks; simultaneous wraps at LCM 28 are both seen.
- Restart and reset interplay:
  - restart with en=1 at count=300 gives count 0 and out 0 on the next edge.
  - reset_n pulled low between edges clears count, out, and wrap immediately.
  - After release, the sequence restarts from 0 identical to the first run.

Source files
------------

// File: rtl/pipe_rate_gen_if.sv
// Control and strobe bundle between the rate generator and its game-logic consumers.
// Channel i of period/thresh/count sits at [i*WIDTH +: WIDTH].
interface pipe_rate_gen_if #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2
);
  logic                      en;
  logic                      restart;
  logic [CHANNELS-1:0]       mode;
  logic [CHANNELS*WIDTH-1:0] period;
  logic [CHANNELS*WIDTH-1:0] thresh;
  logic [CHANNELS-1:0]       out;
  logic [CHANNELS-1:0]       wrap;
  logic [CHANNELS*WIDTH-1:0] count;

  modport master (
    output en, restart, mode, period, thresh,
    input  out, wrap, count
  );

  modport slave (
    input  en, restart, mode, period, thresh,
    output out, wrap, count
  );
endinterface

// File: rtl/pipe_rate_gen.sv
// Multi-channel programmable rate generator; out/wrap are registered from the pre-edge count.
// No backpressure: en=0 freezes every counter, restart re-phases all channels to zero.
module pipe_rate_gen #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2
) (
  input logic            clk,
  input logic            reset_n,
  pipe_rate_gen_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [CHANNELS*WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]       out_q, out_d;
  logic [CHANNELS-1:0]       wrap_q, wrap_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] c, p, t;
    logic             hit, lvl;

    assign c = cnt_q[i*WIDTH +: WIDTH];
    assign p = bus.period[i*WIDTH +: WIDTH];
    assign t = bus.thresh[i*WIDTH +: WIDTH];

    // >= rather than == so a period lowered below the live count wraps at once.
    assign hit = (c >= p);
    assign lvl = bus.mode[i] ? hit : (c > t);

    assign cnt_d[i*WIDTH +: WIDTH] = bus.restart ? '0 :
                                     (!bus.en ? c : (hit ? '0 : c + ONE));
    assign wrap_d[i] = !bus.restart && bus.en && hit;
    // While paused a level output holds its value but a pulse output drops.
    assign out_d[i]  = bus.restart ? 1'b0 :
                       (bus.en ? lvl : (!bus.mode[i] && out_q[i]));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      out_q  <= '0;
      wrap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.count = cnt_q;
  assign bus.out   = out_q;
  assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_pipe_rate_gen.sv
// Directed bench for pipe_rate_gen: two 10-bit channels, expectations hand-derived.
module tb_pipe_rate_gen;
  logic clk;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe_rate_gen_if #(.WIDTH(10), .CHANNELS(2)) ifc ();

  pipe_rate_gen #(.WIDTH(10), .CHANNELS(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] cnt(input int ch);
    return ifc.count[ch*10 +: 10];
  endfunction

  // Restart pulse for one edge; leaves restart low afterwards.
  task automatic do_restart();
    ifc.restart = 1'b1;
    tick(1);
    ifc.restart = 1'b0;
  endtask

  initial begin
    int hi0, p1, both, both_at;
    logic [9:0] exp_cnt [10];
    logic       exp_pls [10];

    reset_n     = 1'b0;
    ifc.en      = 1'b0;
    ifc.restart = 1'b0;
    ifc.mode    = 2'b00;
    ifc.period  = {10'd1023, 10'd1023};
    ifc.thresh  = {10'd511, 10'd511};
    #12;
    chk("reset_count", ifc.count, 0);
    chk("reset_out",   ifc.out,   0);
    chk("reset_wrap",  ifc.wrap,  0);

    // Default 50% square wave, P=1023 T=511; first posedge after release is edge 1.
    #1;
    reset_n = 1'b1;
    ifc.en  = 1'b1;
    tick(512);
    chk("sq_e512_out", ifc.out[0], 0);
    chk("sq_e512_cnt", cnt(0), 512);
    tick(1);
    chk("sq_e513_out", ifc.out[0], 1);
    tick(510);
    chk("sq_e1023_cnt",  cnt(0), 1023);
    chk("sq_e1023_wrap", ifc.wrap[0], 0);
    tick(1);
    chk("sq_e1024_cnt",  cnt(0), 0);
    chk("sq_e1024_wrap", ifc.wrap[0], 1);
    chk("sq_e1024_out",  ifc.out[0], 1);
    tick(1);
    chk("sq_e1025_out",  ifc.out[0], 0);
    chk("sq_e1025_wrap", ifc.wrap[0], 0);
    chk("sq_e1025_cnt",  cnt(0), 1);
    hi0  = 0;
    p1   = 0;
    both = 0;
    for (int k = 0; k < 1024; k++) begin
      tick(1);
      if (ifc.out[0])  hi0++;
      if (ifc.wrap[0]) p1++;
    end
    chk("sq_high_per_period", hi0, 512);
    chk("sq_wrap_per_period", p1, 1);

    // Pulse mode P=4: count 1,2,3,4,0 and a pulse on the edge leaving 4.
    exp_cnt = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd0};
    exp_pls = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ifc.mode   = 2'b01;
    ifc.period = {10'd1023, 10'd4};
    do_restart();
    chk("rst_cnt", cnt(0), 0);
    chk("rst_out", ifc.out[0], 0);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk($sformatf("pls_cnt_%0d", k + 1), cnt(0), exp_cnt[k]);
      chk($sformatf("pls_out_%0d", k + 1), ifc.out[0], exp_pls[k]);
      chk($sformatf("pls_wrap_%0d", k + 1), ifc.wrap[0], exp_pls[k]);
    end
    ifc.period = {10'd1023, 10'd0};
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("p0_cnt",  cnt(0), 0);
      chk("p0_out",  ifc.out[0], 1);
      chk("p0_wrap", ifc.wrap[0], 1);
    end

    // Enable gating, level mode P=9 T=4: pause at count 7.
    ifc.mode   = 2'b00;
    ifc.period = {10'd1023, 10'd9};
    ifc.thresh = {10'd511, 10'd4};
    do_restart();
    tick(7);
    chk("gate_pre_cnt", cnt(0), 7);
    chk("gate_pre_out", ifc.out[0], 1);
    ifc.en = 1'b0;
    tick(6);
    chk("gate_hold_cnt",  cnt(0), 7);
    chk("gate_hold_out",  ifc.out[0], 1);
    chk("gate_hold_wrap", ifc.wrap[0], 0);
    ifc.en = 1'b1;
    tick(2);
    chk("gate_res2_cnt",  cnt(0), 9);
    chk("gate_res2_wrap", ifc.wrap[0], 0);
    tick(1);
    chk("gate_res3_cnt",  cnt(0), 0);
    chk("gate_res3_wrap", ifc.wrap[0], 1);
    chk("gate_res3_out",  ifc.out[0], 1);
    tick(1);
    chk("gate_res4_out",  ifc.out[0], 0);

    // Same in pulse mode: pause right after a pulse, the pulse must not persist.
    ifc.mode = 2'b01;
    do_restart();
    tick(10);
    chk("pgate_pulse", ifc.out[0], 1);
    ifc.en = 1'b0;
    tick(1);
    chk("pgate_pause_out",  ifc.out[0], 0);
    chk("pgate_pause_wrap", ifc.wrap[0], 0);
    tick(5);
    chk("pgate_hold_out", ifc.out[0], 0);
    chk("pgate_hold_cnt", cnt(0), 0);
    ifc.en = 1'b1;
    tick(9);
    chk("pgate_res9_cnt", cnt(0), 9);
    chk("pgate_res9_out", ifc.out[0], 0);
    tick(1);
    chk("pgate_res10_out",  ifc.out[0], 1);
    chk("pgate_res10_wrap", ifc.wrap[0], 1);

    // Period shrink from 99 to 20 while count is 50.
    ifc.mode   = 2'b00;
    ifc.period = {10'd1023, 10'd99};
    ifc.thresh = {10'd511, 10'd99};
    do_restart();
    tick(50);
    chk("shrink_pre_cnt", cnt(0), 50);
    ifc.period = {10'd1023, 10'd20};
    tick(1);
    chk("shrink_cnt",  cnt(0), 0);
    chk("shrink_wrap", ifc.wrap[0], 1);
    tick(20);
    chk("shrink_p20_cnt",  cnt(0), 20);
    chk("shrink_p20_wrap", ifc.wrap[0], 0);
    tick(1);
    chk("shrink_p21_cnt",  cnt(0), 0);
    chk("shrink_p21_wrap", ifc.wrap[0], 1);

    // Two channels: ch0 P=3 T=1 level, ch1 P=6 pulse, over 42 edges.
    ifc.mode   = 2'b10;
    ifc.period = {10'd6, 10'd3};
    ifc.thresh = {10'd0, 10'd1};
    do_restart();
    hi0     = 0;
    p1      = 0;
    both    = 0;
    both_at = -1;
    for (int k = 1; k <= 42; k++) begin
      tick(1);
      if (ifc.out[0]) hi0++;
      if (ifc.out[1]) p1++;
      if (ifc.wrap == 2'b11) begin
        both++;
        both_at = k;
      end
      if (k <= 4) chk($sformatf("dual_ch0_out_%0d", k), ifc.out[0], (k >= 3) ? 1 : 0);
    end
    chk("dual_ch0_high", hi0, 20);
    chk("dual_ch1_pulses", p1, 6);
    chk("dual_both_wraps", both, 1);
    chk("dual_both_at", both_at, 28);

    // Restart with en=1 at count 300, level T=100 so out is high beforehand.
    ifc.mode   = 2'b00;
    ifc.period = {10'd1023, 10'd1023};
    ifc.thresh = {10'd511, 10'd100};
    do_restart();
    tick(300);
    chk("rs_pre_cnt", cnt(0), 300);
    chk("rs_pre_out", ifc.out[0], 1);
    do_restart();
    chk("rs_cnt",  cnt(0), 0);
    chk("rs_out",  ifc.out[0], 0);
    chk("rs_wrap", ifc.wrap[0], 0);

    // Async reset between edges: ch0 level P=9 T=2, ch1 pulse P=4.
    ifc.mode   = 2'b10;
    ifc.period = {10'd4, 10'd9};
    ifc.thresh = {10'd0, 10'd2};
    do_restart();
    tick(5);
    chk("ar_pre_cnt0",  cnt(0), 5);
    chk("ar_pre_out",   ifc.out, 2'b11);
    chk("ar_pre_wrap1", ifc.wrap[1], 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_cnt",  ifc.count, 0);
    chk("ar_out",  ifc.out,   0);
    chk("ar_wrap", ifc.wrap,  0);
    tick(2);
    chk("ar_held_cnt", ifc.count, 0);
    #2;
    reset_n = 1'b1;
    tick(1);
    chk("ar_rel1_cnt0", cnt(0), 1);
    chk("ar_rel1_out",  ifc.out, 0);
    tick(4);
    chk("ar_rel5_cnt0", cnt(0), 5);
    chk("ar_rel5_cnt1", cnt(1), 0);
    chk("ar_rel5_out",  ifc.out, 2'b11);
    chk("ar_rel5_wrap", ifc.wrap, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
